// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl
// Pops raw scan-code bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes
// into complete make/break events, tracks held keys and modifier state, and
// queues events for downstream consumers behind a valid/ready handshake.
module kbd_event_ctrl #(
    parameter int DEPTH     = 4,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_repeat,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic [7:0] drop_cnt,
    output logic       rx_ovf
);

    // Pointer width; DEPTH is a power of two in 2..16 so pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Held-bitmap indices ({ext, code}) of the keys that drive modifiers.
    localparam logic [8:0] IDX_LSHIFT = 9'h012;
    localparam logic [8:0] IDX_RSHIFT = 9'h059;
    localparam logic [8:0] IDX_LCTRL  = 9'h014;
    localparam logic [8:0] IDX_RCTRL  = 9'h114;
    localparam logic [8:0] IDX_CAPS   = 9'h058;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CL_EXT  = 2'd0,
        CL_BRK  = 2'd1,
        CL_DROP = 2'd2,
        CL_KEY  = 2'd3
    } cls_t;

    // Sort a received byte into prefix, protocol noise, or key code.
    function automatic cls_t classify_byte(input logic [7:0] b);
        cls_t c;
        case (b)
            8'hE0:   c = CL_EXT;
            8'hF0:   c = CL_BRK;
            8'hFA, 8'hAA, 8'hEE, 8'hFE,
            8'h00, 8'hFF, 8'hE1: c = CL_DROP;
            default: c = CL_KEY;
        endcase
        return c;
    endfunction

    // FSM and byte capture
    state_t      state_r;
    state_t      state_s;
    logic [7:0]  byte_r;
    logic        nextdata_n_r;

    // Prefix tracking and key state
    logic        ext_p_r;
    logic        ext_p_s;
    logic        brk_p_r;
    logic        brk_p_s;
    logic [511:0] held_r;
    logic [511:0] held_s;
    logic        caps_r;
    logic        caps_s;
    logic        shift_r;
    logic        shift_s;
    logic        ctrl_r;
    logic        ctrl_s;

    // Event produced by the byte being classified this cycle
    logic        ev_fire_s;
    logic        ev_rep_s;
    logic [10:0] ev_word_s;
    logic [8:0]  idx_s;

    // Event FIFO: entry = {repeat, break, ext, code}
    logic [10:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic [AW:0]   cnt_s;
    logic          ev_valid_r;
    logic          rd_s;
    logic          wr_s;
    logic          full_s;
    logic          drop_s;

    // Status
    logic [7:0]  drop_cnt_r;
    logic        rx_ovf_r;

    // Next-state, classification, bitmap and modifier update.
    always_comb begin
        state_s   = state_r;
        ext_p_s   = ext_p_r;
        brk_p_s   = brk_p_r;
        held_s    = held_r;
        caps_s    = caps_r;
        ev_fire_s = 1'b0;
        ev_rep_s  = 1'b0;
        idx_s     = {ext_p_r, byte_r};
        ev_word_s = 11'h000;
        case (state_r)
            ST_IDLE: begin
                if (ready) begin
                    state_s = ST_POP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POP: begin
                state_s = ST_SETTLE;
                case (classify_byte(byte_r))
                    CL_EXT: ext_p_s = 1'b1;
                    CL_BRK: brk_p_s = 1'b1;
                    CL_DROP: begin
                        ext_p_s = 1'b0;
                        brk_p_s = 1'b0;
                    end
                    CL_KEY: begin
                        ext_p_s = 1'b0;
                        brk_p_s = 1'b0;
                        ev_rep_s = ~brk_p_r & held_r[idx_s];
                        // A break releases the key; a make marks it held.
                        held_s[idx_s] = ~brk_p_r;
                        if (~brk_p_r && ~ev_rep_s && (idx_s == IDX_CAPS)) begin
                            caps_s = ~caps_r;
                        end else begin
                            caps_s = caps_r;
                        end
                        // Repeated makes are only forwarded when tagging is enabled.
                        ev_fire_s = ~ev_rep_s | REPEAT_EN;
                        ev_word_s = {ev_rep_s, brk_p_r, ext_p_r, byte_r};
                    end
                    default: begin
                        ext_p_s = 1'b0;
                        brk_p_s = 1'b0;
                    end
                endcase
            end
            ST_SETTLE: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
        shift_s = held_s[IDX_LSHIFT] | held_s[IDX_RSHIFT];
        ctrl_s  = held_s[IDX_LCTRL]  | held_s[IDX_RCTRL];
    end

    // FIFO handshake: read/write/drop decisions and occupancy update.
    always_comb begin
        rd_s   = ev_valid_r & ev_ready;
        full_s = (cnt_r == FULL_CNT);
        wr_s   = ev_fire_s & (~full_s | rd_s);
        drop_s = ev_fire_s & full_s & ~rd_s;
        case ({wr_s, rd_s})
            2'b10:   cnt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_s = cnt_r - CNT_ONE;
            default: cnt_s = cnt_r;
        endcase
    end

    // FSM state, byte capture and the registered pop strobe (low only in POP).
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r      <= ST_IDLE;
            byte_r       <= 8'h00;
            nextdata_n_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            nextdata_n_r <= (state_s != ST_POP);
            if ((state_r == ST_IDLE) && ready) begin
                byte_r <= data;
            end
        end
    end

    // Prefix flags, held-key bitmap and modifier registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ext_p_r <= 1'b0;
            brk_p_r <= 1'b0;
            held_r  <= '0;
            caps_r  <= 1'b0;
            shift_r <= 1'b0;
            ctrl_r  <= 1'b0;
        end else begin
            ext_p_r <= ext_p_s;
            brk_p_r <= brk_p_s;
            held_r  <= held_s;
            caps_r  <= caps_s;
            shift_r <= shift_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // Event FIFO storage and pointers; storage is cleared so the idle head reads zero.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 11'h000;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            ev_valid_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= ev_word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r      <= cnt_s;
            ev_valid_r <= (cnt_s != '0);
        end
    end

    // Saturating drop counter and sticky receiver-overflow flag.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            drop_cnt_r <= 8'h00;
            rx_ovf_r   <= 1'b0;
        end else begin
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'h01;
            end
            if (overflow) begin
                rx_ovf_r <= 1'b1;
            end
        end
    end

    assign nextdata_n = nextdata_n_r;
    assign ev_valid   = ev_valid_r;
    assign ev_repeat  = mem_r[rd_ptr_r][10];
    assign ev_break   = mem_r[rd_ptr_r][9];
    assign ev_ext     = mem_r[rd_ptr_r][8];
    assign ev_code    = mem_r[rd_ptr_r][7:0];
    assign shift      = shift_r;
    assign ctrl       = ctrl_r;
    assign caps       = caps_r;
    assign drop_cnt   = drop_cnt_r;
    assign rx_ovf     = rx_ovf_r;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: two instances (repeats dropped / repeats tagged)
// share one modelled receiver FIFO; a byte-level reference model predicts the
// event queue, modifiers, drop count and overflow flag every cycle.
module tb_kbd_event_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       clrn, ready, overflow, ev_ready;
    logic [7:0] data;

    logic       nd_a, ev_valid_a, ev_ext_a, ev_brk_a, ev_rep_a, shift_a, ctrl_a, caps_a, rx_ovf_a;
    logic [7:0] ev_code_a, drop_a;
    logic       nd_b, ev_valid_b, ev_ext_b, ev_brk_b, ev_rep_b, shift_b, ctrl_b, caps_b, rx_ovf_b;
    logic [7:0] ev_code_b, drop_b;

    always #5 clk = ~clk;

    kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_EN(1'b0)) dut_a (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nd_a), .ev_valid(ev_valid_a), .ev_ready(ev_ready),
        .ev_code(ev_code_a), .ev_ext(ev_ext_a), .ev_break(ev_brk_a), .ev_repeat(ev_rep_a),
        .shift(shift_a), .ctrl(ctrl_a), .caps(caps_a), .drop_cnt(drop_a), .rx_ovf(rx_ovf_a)
    );

    kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_EN(1'b1)) dut_b (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nd_b), .ev_valid(ev_valid_b), .ev_ready(ev_ready),
        .ev_code(ev_code_b), .ev_ext(ev_ext_b), .ev_break(ev_brk_b), .ev_repeat(ev_rep_b),
        .shift(shift_b), .ctrl(ctrl_b), .caps(caps_b), .drop_cnt(drop_b), .rx_ovf(rx_ovf_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit prev_low = 1'b0;

    logic [7:0]  rxq[$];
    logic [10:0] log_a[$];
    logic [10:0] log_b[$];
    int          lows[$];

    // Reference model state, index 0 = repeats dropped, 1 = repeats tagged
    bit          held_m [2][512];
    bit          ext_m  [2];
    bit          brk_m  [2];
    bit          caps_m [2];
    logic [10:0] fifo_m [2][DEPTH];
    int          head_m [2];
    int          cnt_m  [2];
    int          drop_m [2];
    bit          ovf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 512; k++) held_m[i][k] = 1'b0;
            ext_m[i] = 1'b0; brk_m[i] = 1'b0; caps_m[i] = 1'b0;
            head_m[i] = 0; cnt_m[i] = 0; drop_m[i] = 0;
        end
        ovf_m = 1'b0;
    endtask

    task automatic model_step(input int i, input bit rd_req, input bit got,
                              input logic [7:0] b, input bit rep_en);
        bit rdv, full, fire, rep;
        int idx;
        logic [10:0] word;
        rdv  = rd_req && (cnt_m[i] != 0);
        full = (cnt_m[i] == DEPTH);
        fire = 1'b0;
        word = 11'h000;
        if (got) begin
            if (b == 8'hE0) ext_m[i] = 1'b1;
            else if (b == 8'hF0) brk_m[i] = 1'b1;
            else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1}) begin
                ext_m[i] = 1'b0; brk_m[i] = 1'b0;
            end else begin
                idx  = (ext_m[i] ? 256 : 0) + int'(b);
                rep  = !brk_m[i] && held_m[i][idx];
                held_m[i][idx] = !brk_m[i];
                if (idx == 'h58 && !brk_m[i] && !rep) caps_m[i] = !caps_m[i];
                fire = !rep || rep_en;
                word = {rep, brk_m[i], ext_m[i], b};
                ext_m[i] = 1'b0; brk_m[i] = 1'b0;
            end
        end
        if (rdv) begin
            head_m[i] = (head_m[i] + 1) % DEPTH;
            cnt_m[i]--;
        end
        if (fire) begin
            if (full && !rdv) begin
                if (drop_m[i] < 255) drop_m[i]++;
            end else begin
                fifo_m[i][(head_m[i] + cnt_m[i]) % DEPTH] = word;
                cnt_m[i]++;
            end
        end
    endtask

    task automatic chk_inst(input string p, input int i, input logic v, input logic [7:0] code,
                            input logic ext, input logic brk, input logic rep, input logic sh,
                            input logic ct, input logic cp, input logic [7:0] dc, input logic ov);
        logic [10:0] hd;
        chk({p, "ev_valid"}, {31'd0, v}, {31'd0, cnt_m[i] != 0});
        if (cnt_m[i] != 0) begin
            hd = fifo_m[i][head_m[i]];
            chk({p, "ev_head"}, {21'd0, rep, brk, ext, code}, {21'd0, hd});
        end
        chk({p, "shift"}, {31'd0, sh}, {31'd0, held_m[i]['h012] | held_m[i]['h059]});
        chk({p, "ctrl"},  {31'd0, ct}, {31'd0, held_m[i]['h014] | held_m[i]['h114]});
        chk({p, "caps"},  {31'd0, cp}, {31'd0, caps_m[i]});
        chk({p, "drop_cnt"}, {24'd0, dc}, drop_m[i]);
        chk({p, "rx_ovf"}, {31'd0, ov}, {31'd0, ovf_m});
    endtask

    task automatic drive_rx();
        ready = (rxq.size() != 0);
        data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        rxq.push_back(b);
        drive_rx();
    endtask

    // One clock: note handshakes, advance receiver and model, then compare.
    task automatic tick();
        bit nd0, rst0, ov0, rr0, got;
        logic [7:0] b;
        nd0 = (nd_a === 1'b0) ? 1'b0 : 1'b1;
        rst0 = !clrn; ov0 = overflow; rr0 = ev_ready;
        if (ev_valid_a === 1'b1 && ev_ready) log_a.push_back({ev_rep_a, ev_brk_a, ev_ext_a, ev_code_a});
        if (ev_valid_b === 1'b1 && ev_ready) log_b.push_back({ev_rep_b, ev_brk_b, ev_ext_b, ev_code_b});
        @(posedge clk);
        #1;
        cyc++;
        got = 1'b0;
        b = 8'h00;
        if (!nd0 && rxq.size() != 0) begin
            b = rxq.pop_front();
            got = 1'b1;
        end
        if (rst0) model_reset();
        else begin
            if (ov0) ovf_m = 1'b1;
            model_step(0, rr0, got, b, 1'b0);
            model_step(1, rr0, got, b, 1'b1);
        end
        drive_rx();
        if (nd_a === 1'b0) lows.push_back(cyc);
        chk("nd_single", (prev_low && nd_a === 1'b0) ? 32'd1 : 32'd0, 32'd0);
        prev_low = (nd_a === 1'b0);
        chk_inst("a_", 0, ev_valid_a, ev_code_a, ev_ext_a, ev_brk_a, ev_rep_a,
                 shift_a, ctrl_a, caps_a, drop_a, rx_ovf_a);
        chk_inst("b_", 1, ev_valid_b, ev_code_b, ev_ext_b, ev_brk_b, ev_rep_b,
                 shift_b, ctrl_b, caps_b, drop_b, rx_ovf_b);
    endtask

    task automatic drain_rx(input int budget);
        int n;
        n = 0;
        while (rxq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("rx_drain_timeout", rxq.size(), 32'd0);
        repeat (4) tick();
    endtask

    task automatic wait_pop(input int budget);
        int n;
        n = 0;
        while (nd_a !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("pop_timeout", {31'd0, nd_a}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "nextdata_n"}, {30'd0, nd_a, nd_b}, 32'd3);
        chk({p, "ev_valid"},   {30'd0, ev_valid_a, ev_valid_b}, 32'd0);
        chk({p, "ev_fields"},  {ev_code_a, ev_code_b, 5'd0, ev_ext_a, ev_brk_a, ev_rep_a,
                                5'd0, ev_ext_b, ev_brk_b, ev_rep_b}, 32'd0);
        chk({p, "mods"},       {26'd0, shift_a, ctrl_a, caps_a, shift_b, ctrl_b, caps_b}, 32'd0);
        chk({p, "drop_ovf"},   {14'd0, drop_a, drop_b, rx_ovf_a, rx_ovf_b}, 32'd0);
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] r;
        case ($urandom_range(0, 15))
            0: r = 8'h12;  1: r = 8'h59;  2: r = 8'h14;  3: r = 8'h58;
            4: r = 8'h1C;  5: r = 8'h1B;  6: r = 8'h23;  7: r = 8'hE0;
            8: r = 8'hE0;  9: r = 8'hF0;  10: r = 8'hF0; 11: r = 8'hF0;
            12: r = 8'hFA; 13: r = 8'hE1; 14: r = 8'h00;
            default: r = 8'($urandom_range(0, 255));
        endcase
        return r;
    endfunction

    initial begin
        clrn = 1'b0; ready = 1'b0; data = 8'h00; overflow = 1'b0; ev_ready = 1'b1;
        model_reset();
        repeat (2) tick();
        chk_reset_outputs("rst_");
        clrn = 1'b1;
        repeat (2) tick();

        // Make and break of one key, with pop cadence
        lows.delete(); log_a.delete();
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain_rx(60);
        chk("t1_lows", lows.size(), 32'd3);
        if (lows.size() == 3) begin
            chk("t1_gap0", lows[1] - lows[0], 32'd3);
            chk("t1_gap1", lows[2] - lows[1], 32'd3);
        end
        chk("t1_count", log_a.size(), 32'd2);
        if (log_a.size() == 2) begin
            chk("t1_ev0", {21'd0, log_a[0]}, 32'h01C);
            chk("t1_ev1", {21'd0, log_a[1]}, 32'h21C);
        end

        // Typematic repeat of shift: dropped on A, tagged on B
        log_a.delete(); log_b.delete();
        send(8'h12); send(8'h12); send(8'h15); send(8'hF0); send(8'h12);
        drain_rx(80);
        chk("t2_count_a", log_a.size(), 32'd3);
        chk("t2_count_b", log_b.size(), 32'd4);
        if (log_a.size() == 3) begin
            chk("t2_a0", {21'd0, log_a[0]}, 32'h012);
            chk("t2_a1", {21'd0, log_a[1]}, 32'h015);
            chk("t2_a2", {21'd0, log_a[2]}, 32'h212);
        end
        if (log_b.size() == 4) begin
            chk("t2_b1", {21'd0, log_b[1]}, 32'h412);
            chk("t2_b3", {21'd0, log_b[3]}, 32'h212);
        end

        // Extended right ctrl
        log_a.delete();
        send(8'hE0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
        drain_rx(80);
        chk("t3_count", log_a.size(), 32'd2);
        if (log_a.size() == 2) begin
            chk("t3_ev0", {21'd0, log_a[0]}, 32'h114);
            chk("t3_ev1", {21'd0, log_a[1]}, 32'h314);
        end

        // Caps lock toggling with an ACK byte in between
        log_a.delete();
        send(8'h58); send(8'hFA); send(8'hF0); send(8'h58); send(8'h58);
        drain_rx(80);
        chk("t4_count", log_a.size(), 32'd3);
        chk("t4_caps", {31'd0, caps_a}, 32'd0);

        // Full FIFO with consumer stalled, then drain
        ev_ready = 1'b0;
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34); send(8'h33);
        drain_rx(100);
        chk("t5_drop", {24'd0, drop_a}, 32'd2);
        chk("t5_valid", {31'd0, ev_valid_a}, 32'd1);
        log_a.delete();
        ev_ready = 1'b1;
        repeat (4) tick();
        chk("t5_drain_cnt", log_a.size(), 32'd4);
        chk("t5_empty", {31'd0, ev_valid_a}, 32'd0);
        if (log_a.size() == 4) begin
            chk("t5_ev0", {21'd0, log_a[0]}, 32'h01C);
            chk("t5_ev3", {21'd0, log_a[3]}, 32'h02B);
        end

        // Overflow pulse, shift held, reset in SETTLE with a break pending
        overflow = 1'b1; tick(); overflow = 1'b0; tick();
        chk("t6_ovf_sticky", {31'd0, rx_ovf_a}, 32'd1);
        send(8'h12);
        drain_rx(40);
        chk("t6_shift", {31'd0, shift_a}, 32'd1);
        send(8'hF0);
        wait_pop(20);
        tick();
        clrn = 1'b0; tick(); clrn = 1'b1;
        chk_reset_outputs("t6_");
        log_a.delete();
        send(8'hE0); send(8'h1C);
        drain_rx(40);
        chk("t6_count", log_a.size(), 32'd1);
        if (log_a.size() == 1) chk("t6_ev", {21'd0, log_a[0]}, 32'h11C);

        // Reset during POP discards the byte being popped
        send(8'h23);
        wait_pop(20);
        clrn = 1'b0; tick(); clrn = 1'b1;
        repeat (3) tick();
        chk("t7_abort", {31'd0, ev_valid_a}, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0) send(pick());
            ev_ready = ($urandom_range(0, 3) != 0);
            overflow = ($urandom_range(0, 99) == 0);
            clrn     = ($urandom_range(0, 299) != 0);
            tick();
        end
        overflow = 1'b0; clrn = 1'b1; ev_ready = 1'b1;
        drain_rx(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Sequencing controller between the `ps2_keyboard` receiver FIFO and the ASCII/display consumers. It pops raw scan-code bytes through the receiver's `ready`/`nextdata_n` handshake and folds `E0`/`F0` prefixes into complete make/break events. It suppresses or tags typematic repeats, tracks modifier state (shift, ctrl, caps lock), and queues events in a small FIFO with a valid/ready output handshake. It replaces ad-hoc per-consumer scan-code decoding, so several downstream blocks read one clean event stream.

## Interface
- `DEPTH`, 4, event FIFO entries (power of two, 2..16)
- `REPEAT_EN`, 0, 1: forward repeated makes of held keys with `ev_repeat`=1; 0: drop them
- `clk`  in  1  system clock, all logic on rising edge
- `clrn`  in  1  reset; one clock, reset is synchronous and active-low
- `ready`  in  1  receiver FIFO non-empty
- `data`  in  8  receiver FIFO head byte
- `overflow`  in  1  receiver FIFO overflow flag
- `nextdata_n`  out  1  active-low pop strobe to receiver
- `ev_valid`  out  1  event FIFO non-empty
- `ev_ready`  in  1  consumer accepts head event
- `ev_code`  out  8  scan code (prefixes stripped)
- `ev_ext`  out  1  event had `E0` prefix
- `ev_break`  out  1  1 = release, 0 = press
- `ev_repeat`  out  1  press of already-held key
- `shift`, `ctrl`, `caps`  out  1 each  live modifier state
- `drop_cnt`  out  8  events lost to full FIFO, saturating at 255
- `rx_ovf`  out  1  sticky: `overflow` seen high

## Operation
- FSM states: IDLE, POP, SETTLE.
  - IDLE with `ready`=1: latch `data` into `byte_q`, go to POP.
  - POP: `nextdata_n`=0 for exactly this cycle, classify `byte_q`, go to SETTLE.
  - SETTLE: one cycle for `ready` to update, then IDLE.
  - `nextdata_n`=1 in every state other than POP.
- Classification of `byte_q`:
  - `E0`: set `ext_p`.
  - `F0`: set `brk_p`.
  - `FA`, `AA`, `EE`, `FE`, `00`, `FF`: discard and clear both pending flags.
  - `E1`: discard and clear both pending flags.
  - Any other byte: completes an event `{ext_p, brk_p, byte_q}`, then clears both pending flags.
- Held bitmap: 512 bits indexed `{ext, code}`.
  - Make: repeat if the bit is already set; otherwise set the bit.
  - Break: clear the bit.
  - Repeat make with `REPEAT_EN`=0: no event is queued.
- Modifiers, derived from the bitmap after update:
  - `shift` = held[0,12] | held[0,59].
  - `ctrl` = held[0,14] | held[1,14].
  - `caps` toggles on a non-repeat make of {0,58}.
- Event FIFO:
  - Write on event completion.
  - Read when `ev_valid & ev_ready`.
  - Full and writing with no simultaneous read: drop the event and increment `drop_cnt` (saturating).
  - Full with a simultaneous read: write succeeds.
  - Empty: `ev_valid`=0; event outputs hold the last head value (don't-care).
- Bitmap and modifier updates happen even when the event is dropped.
- `rx_ovf` sets on any cycle `overflow`=1 and clears only on reset.

## Timing
- Reset (`clrn`=0 at rising edge) takes effect on that edge. All outputs after reset:
  - `nextdata_n`=1, `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_break`=0, `ev_repeat`=0.
  - `shift`=0, `ctrl`=0, `caps`=0, `drop_cnt`=0, `rx_ovf`=0.
- What reset clears internally: FSM to IDLE, bitmap, pending flags and FIFO pointers.
- Reset in POP or SETTLE aborts the pop: no event is queued from that byte.
- Throughput: 1 byte per 3 cycles max.
- Latency: final byte sampled in IDLE at cycle t gives `ev_valid`=1 and modifier update at t+2. `shift`, `ctrl` and `caps` change in the same cycle the event is written.
- The head event is stable while `ev_valid`=1 and `ev_ready`=0.
- The FIFO supports simultaneous read and write every cycle.

## Test plan
- Bytes `1C`, `F0`, `1C` -> two events, in order:
  - {ext0, brk0, rep0, `1C`}.
  - {ext0, brk1, rep0, `1C`}.
  - `nextdata_n` low exactly 3 single cycles, each 3 cycles apart.
- Bytes `12`, `12`, `15`, `F0`, `12` (`REPEAT_EN`=0) -> 3 events: `12` make, `15` make, `12` break.
  - `shift`=1 from the first event until the `12` break.
  - With `REPEAT_EN`=1: 4 events, the second has `ev_repeat`=1.
- Bytes `E0`, `14`, `E0`, `F0`, `14` -> two events with `ev_ext`=1 and code `14`.
  - `ctrl` is 1 between the two events.
- Bytes `58`, `F0`, `58`, `58` -> `caps` goes 0→1→1→0.
  - `FA` inserted between events produces no event and no state change.
- `ev_ready`=0, 6 distinct makes with `DEPTH`=4 -> 4 queued, `drop_cnt`=2.
  - Then `ev_ready`=1 -> the 4 events drain in order, one per cycle.
- `clrn` low during SETTLE, and `overflow` pulse -> all outputs return to reset values.
  - Next byte `E0`, `1C` -> `ev_ext`=1, proving the pending flags restarted clean.
  - `rx_ovf` set by the pulse and cleared only by reset.
